// File: rtl/nvme_doorbell_axil.sv
// Coalescing doorbell writer: queues per-doorbell tail/head updates and drains them as
// single AXI-Lite writes, round-robin across doorbells, one write outstanding at a time.
module nvme_doorbell_axil #(
    parameter int unsigned NL_ADDR_WIDTH = 32,
    parameter int unsigned NL_DATA_WIDTH = 32,
    parameter int unsigned NUM_DB        = 4,
    parameter logic [NL_ADDR_WIDTH-1:0] DB_BASE = 32'h1000,
    parameter int unsigned DSTRD         = 0,
    localparam int unsigned IW = (NUM_DB > 1) ? $clog2(NUM_DB) : 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       db_valid,
    output logic                       db_ready,
    input  logic [IW-1:0]              db_idx,
    input  logic [15:0]                db_value,
    output logic [NL_ADDR_WIDTH-1:0]   nl_awaddr,
    output logic                       nl_awvalid,
    input  logic                       nl_awready,
    output logic [NL_DATA_WIDTH-1:0]   nl_wdata,
    output logic [NL_DATA_WIDTH/8-1:0] nl_wstrb,
    output logic                       nl_wvalid,
    input  logic                       nl_wready,
    input  logic [1:0]                 nl_bresp,
    input  logic                       nl_bvalid,
    output logic                       nl_bready,
    output logic                       busy,
    output logic                       err,
    output logic [IW-1:0]              err_idx
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [NUM_DB-1:0] pend_q, pend_d;
    logic [15:0]       val_q [NUM_DB];
    logic [15:0]       val_d [NUM_DB];
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     cur_idx_q, cur_idx_d;
    logic [15:0]       cur_val_q, cur_val_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              err_q, err_d;
    logic [IW-1:0]     err_idx_q, err_idx_d;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] cand;
    logic          active;

    // First pending doorbell at or after rr_ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int unsigned i = 0; i < NUM_DB; i++) begin
            cand = IW'((32'(rr_ptr_q) + i) % NUM_DB);
            if (!pick_found && pend_q[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        val_d     = val_q;
        rr_ptr_d  = rr_ptr_q;
        cur_idx_d = cur_idx_q;
        cur_val_d = cur_val_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        err_d     = err_q;
        err_idx_d = err_idx_q;

        case (state_q)
            StIdle: begin
                if (pick_found) begin
                    cur_idx_d        = pick_idx;
                    cur_val_d        = val_q[pick_idx];
                    pend_d[pick_idx] = 1'b0;
                    rr_ptr_d         = (pick_idx == IW'(NUM_DB - 1)) ? '0 : pick_idx + 1'b1;
                    aw_done_d        = 1'b0;
                    w_done_d         = 1'b0;
                    state_d          = StAddr;
                end
            end
            StAddr: begin
                aw_done_d = aw_done_q | (nl_awvalid & nl_awready);
                w_done_d  = w_done_q | (nl_wvalid & nl_wready);
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = StResp;
                end
            end
            StResp: begin
                if (nl_bvalid) begin
                    state_d = StIdle;
                    if (nl_bresp != 2'b00 && !err_q) begin
                        err_d     = 1'b1;
                        err_idx_d = cur_idx_q;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Applied after the pick so a same-cycle request to cur_idx stays pending.
        if (db_valid && (32'(db_idx) < NUM_DB)) begin
            pend_d[db_idx] = 1'b1;
            val_d[db_idx]  = db_value;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            pend_q    <= '0;
            for (int unsigned i = 0; i < NUM_DB; i++) val_q[i] <= '0;
            rr_ptr_q  <= '0;
            cur_idx_q <= '0;
            cur_val_q <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            err_q     <= 1'b0;
            err_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            val_q     <= val_d;
            rr_ptr_q  <= rr_ptr_d;
            cur_idx_q <= cur_idx_d;
            cur_val_q <= cur_val_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            err_q     <= err_d;
            err_idx_q <= err_idx_d;
        end
    end

    assign active     = (state_q != StIdle);
    assign db_ready   = 1'b1;
    assign nl_awvalid = (state_q == StAddr) && !aw_done_q;
    assign nl_wvalid  = (state_q == StAddr) && !w_done_q;
    assign nl_bready  = (state_q == StResp);
    // Address/data buses are held at zero while idle so the block is quiet out of reset.
    assign nl_awaddr  = active ? DB_BASE + (NL_ADDR_WIDTH'(cur_idx_q) << (2 + DSTRD)) : '0;
    assign nl_wdata   = active ? NL_DATA_WIDTH'(cur_val_q) : '0;
    assign nl_wstrb   = active ? '1 : '0;
    assign busy       = (|pend_q) | active;
    assign err        = err_q;
    assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_nvme_doorbell_axil.sv
// Directed bench for nvme_doorbell_axil: expected writes are queued as requests are driven
// and checked at each AW handshake; a DSTRD=1 twin checks the stride.
module tb_nvme_doorbell_axil;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        db_valid, db_ready;
    logic [1:0]  db_idx;
    logic [15:0] db_value;
    logic [31:0] nl_awaddr, nl_wdata;
    logic [3:0]  nl_wstrb;
    logic        nl_awvalid, nl_awready, nl_wvalid, nl_wready;
    logic [1:0]  nl_bresp;
    logic        nl_bvalid, nl_bready, busy, err;
    logic [1:0]  err_idx;

    logic        d1_db_ready, d1_awvalid, d1_wvalid, d1_bready, d1_busy, d1_err;
    logic [31:0] d1_awaddr, d1_wdata;
    logic [3:0]  d1_wstrb;
    logic [1:0]  d1_err_idx;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] val;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  bhs = 0;

    always #5 clk = ~clk;

    nvme_doorbell_axil #(.DSTRD(0)) dut (
        .clk(clk), .rstn(rstn), .db_valid(db_valid), .db_ready(db_ready), .db_idx(db_idx),
        .db_value(db_value), .nl_awaddr(nl_awaddr), .nl_awvalid(nl_awvalid),
        .nl_awready(nl_awready), .nl_wdata(nl_wdata), .nl_wstrb(nl_wstrb),
        .nl_wvalid(nl_wvalid), .nl_wready(nl_wready), .nl_bresp(nl_bresp),
        .nl_bvalid(nl_bvalid), .nl_bready(nl_bready), .busy(busy), .err(err),
        .err_idx(err_idx)
    );

    nvme_doorbell_axil #(.DSTRD(1)) dut_s1 (
        .clk(clk), .rstn(rstn), .db_valid(db_valid), .db_ready(d1_db_ready), .db_idx(db_idx),
        .db_value(db_value), .nl_awaddr(d1_awaddr), .nl_awvalid(d1_awvalid),
        .nl_awready(nl_awready), .nl_wdata(d1_wdata), .nl_wstrb(d1_wstrb),
        .nl_wvalid(d1_wvalid), .nl_wready(nl_wready), .nl_bresp(nl_bresp),
        .nl_bvalid(nl_bvalid), .nl_bready(d1_bready), .busy(d1_busy), .err(d1_err),
        .err_idx(d1_err_idx)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] idx, input logic [15:0] val);
        wr_t e;
        e.idx = idx;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [1:0] idx, input logic [15:0] val);
        db_valid = 1'b1;
        db_idx   = idx;
        db_value = val;
        step();
        db_valid = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound && busy; i++) step();
        chk("idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        step();
    endtask

    // Scoreboard: every AW handshake must match the oldest expected write.
    always @(negedge clk) begin
        if (rstn) begin
            if (nl_awvalid && nl_awready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {32'd0, nl_awaddr}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("awaddr", {32'd0, nl_awaddr}, {32'd0, 32'h1000 + 32'(e.idx) * 4});
                    chk("wdata", {32'd0, nl_wdata}, {48'd0, e.val});
                    chk("wstrb", {60'd0, nl_wstrb}, 64'hF);
                    chk("awaddr_dstrd1", {32'd0, d1_awaddr}, {32'd0, 32'h1000 + 32'(e.idx) * 8});
                end
            end
            if (nl_bready && nl_bvalid) bhs++;
        end
    end

    initial begin
        int b0;
        db_valid   = 1'b0;
        db_idx     = '0;
        db_value   = '0;
        nl_awready = 1'b1;
        nl_wready  = 1'b1;
        nl_bvalid  = 1'b1;
        nl_bresp   = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_db_ready", {63'd0, db_ready}, 64'd1);
        chk("rst_awvalid", {63'd0, nl_awvalid}, 64'd0);
        chk("rst_wvalid", {63'd0, nl_wvalid}, 64'd0);
        chk("rst_bready", {63'd0, nl_bready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_err", {62'd0, err_idx, err}, 64'd0);
        chk("rst_awaddr", {32'd0, nl_awaddr}, 64'd0);
        chk("rst_wstrb", {60'd0, nl_wstrb}, 64'd0);
        rstn = 1'b1;
        step();

        // T1: single write, latency N+2, busy drops after the bvalid cycle.
        push(2'd0, 16'd5);
        send(2'd0, 16'd5);
        chk("t1_awvalid_n1", {63'd0, nl_awvalid}, 64'd0);
        chk("t1_busy_n1", {63'd0, busy}, 64'd1);
        step();
        chk("t1_awvalid_n2", {63'd0, nl_awvalid}, 64'd1);
        chk("t1_wvalid_n2", {63'd0, nl_wvalid}, 64'd1);
        step();
        chk("t1_bready", {63'd0, nl_bready}, 64'd1);
        chk("t1_busy_resp", {63'd0, busy}, 64'd1);
        step();
        chk("t1_busy_done", {63'd0, busy}, 64'd0);

        // T2: coalescing while idx0 stalls on awready.
        nl_awready = 1'b0;
        push(2'd0, 16'd9);
        push(2'd1, 16'd7);
        send(2'd0, 16'd9);
        send(2'd1, 16'd3);
        send(2'd1, 16'd7);
        repeat (3) step();
        nl_awready = 1'b1;
        wait_idle(20);
        chk("t2_queue_empty", 64'(exp_q.size()), 64'd0);

        // T3: 3,1,2 queued behind a stalled idx0 write (rr_ptr then 1) -> order 1,2,3.
        do_reset();
        nl_awready = 1'b0;
        push(2'd0, 16'h10);
        push(2'd1, 16'h11);
        push(2'd2, 16'h12);
        push(2'd3, 16'h13);
        send(2'd0, 16'h10);
        send(2'd3, 16'h13);
        send(2'd1, 16'h11);
        send(2'd2, 16'h12);
        step();
        nl_awready = 1'b1;
        wait_idle(40);
        chk("t3_queue_empty", 64'(exp_q.size()), 64'd0);

        // T4: awready late by 3 cycles, wready immediate.
        nl_awready = 1'b0;
        push(2'd2, 16'h22);
        send(2'd2, 16'h22);
        step();
        chk("t4_awvalid_c0", {63'd0, nl_awvalid}, 64'd1);
        chk("t4_wvalid_c0", {63'd0, nl_wvalid}, 64'd1);
        chk("t4_awaddr_c0", {32'd0, nl_awaddr}, 64'h1008);
        step();
        chk("t4_wvalid_c1", {63'd0, nl_wvalid}, 64'd0);
        chk("t4_awvalid_c1", {63'd0, nl_awvalid}, 64'd1);
        chk("t4_awaddr_c1", {32'd0, nl_awaddr}, 64'h1008);
        step();
        chk("t4_awvalid_c2", {63'd0, nl_awvalid}, 64'd1);
        chk("t4_awaddr_c2", {32'd0, nl_awaddr}, 64'h1008);
        nl_awready = 1'b1;
        b0 = bhs;
        wait_idle(10);
        chk("t4_one_bhandshake", 64'(bhs - b0), 64'd1);

        // T5: error capture is sticky on the first failing doorbell.
        nl_bresp = 2'b10;
        push(2'd2, 16'h2);
        send(2'd2, 16'h2);
        wait_idle(10);
        chk("t5_err_first", {63'd0, err}, 64'd1);
        chk("t5_err_idx_first", {62'd0, err_idx}, 64'd2);
        nl_bresp = 2'b11;
        push(2'd0, 16'h3);
        send(2'd0, 16'h3);
        wait_idle(10);
        chk("t5_err_second", {63'd0, err}, 64'd1);
        chk("t5_err_idx_kept", {62'd0, err_idx}, 64'd2);
        nl_bresp = 2'b00;
        push(2'd1, 16'h4);
        send(2'd1, 16'h4);
        wait_idle(10);
        chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

        // T6: reset while in RESP with idx1 pending.
        nl_bvalid = 1'b0;
        push(2'd0, 16'h6);
        send(2'd0, 16'h6);
        send(2'd1, 16'h16);
        step();
        chk("t6_in_resp", {63'd0, nl_bready}, 64'd1);
        chk("t6_busy_before", {63'd0, busy}, 64'd1);
        rstn = 1'b0;
        #1;
        chk("t6_awvalid", {63'd0, nl_awvalid}, 64'd0);
        chk("t6_wvalid", {63'd0, nl_wvalid}, 64'd0);
        chk("t6_bready", {63'd0, nl_bready}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_err", {62'd0, err_idx, err}, 64'd0);
        chk("t6_awaddr_wdata", {nl_awaddr, nl_wdata}, 64'd0);
        chk("t6_db_ready", {63'd0, db_ready}, 64'd1);
        step();
        rstn = 1'b1;
        nl_bvalid = 1'b1;
        repeat (6) step();
        chk("t6_busy_after", {63'd0, busy}, 64'd0);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
